puf_test_ctrl: RTL and testbench
================================

PUF_TEST_CTRL -- requirements
Module: puf_test_ctrl

Interface
REQ-001 Parameters SHALL be: N_CB 64, challenge width; N_TESTS 8, test-result bits (1..8); ROUND_BITS 20000, test bits per round; N_ROUNDS 255, rounds per run (1..255); ADDR_W 13, memory address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk, in, 1: single clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run.
- mode, in, 2: 0 = raw, 1 = XOR pair, 2 = decimate-by-2, 3 = reserved, treated as 0.
- base_addr, in, ADDR_W: first memory address of the summary.
- C, in, N_CB: free-running challenge from the generator.
- challenge, out, N_CB: challenge to the PUF.
- response, in, 1: PUF response bit.
- test_data, out, 1: bit to the test block.
- test_valid, out, 1: test block clock enable; replaces the clock mux.
- test_result, in, N_TESTS: pass flags from the test block.
- mem_we, out, 1: memory write enable.
- mem_waddr, out, ADDR_W: memory write address.
- mem_din, out, 8: memory write data.
- busy, out, 1: run in progress.
- done, out, 1: summary stored.

Function
REQ-003 States SHALL be IDLE, RUN, SAMPLE, STORE, DONE.
REQ-004 IDLE: on start=1, clear all counters, latch mode and base_addr, go to RUN; start is ignored in every other state except DONE.
REQ-005 Entering RUN SHALL assert busy; busy SHALL stay 1 through RUN, SAMPLE and STORE.
REQ-006 In RUN, SAMPLE and STORE, challenge SHALL load C every cycle; each cycle's response is the answer to the previous cycle's challenge.
REQ-007 mode 0: every cycle, test_data <= response and test_valid <= 1.
REQ-008 mode 1: bits are paired (first, second); on the second cycle, test_data <= first XOR second and test_valid <= 1; otherwise test_valid <= 0.
REQ-009 mode 2: on the first cycle of each pair, test_data <= response and test_valid <= 1; on the second cycle, test_valid <= 0.
REQ-010 The pair phase SHALL reset to "first" on entry to RUN and SHALL continue across SAMPLE.
REQ-011 bit_cnt SHALL count cycles with test_valid=1; when a valid bit makes it ROUND_BITS, go to SAMPLE and clear bit_cnt.
REQ-012 SAMPLE lasts one cycle and keeps feeding bits per REQ-007..009; those bits count toward the next round.
REQ-013 In SAMPLE, each 8-bit pass counter i SHALL add test_result[i] and saturate at 255; round_cnt SHALL increment.
REQ-014 From SAMPLE: if round_cnt reaches N_ROUNDS go to STORE, else back to RUN.
REQ-015 STORE SHALL write exactly N_TESTS words, one per cycle: mem_we=1, mem_waddr=base_addr+i, mem_din=pass counter i, i = 0..N_TESTS-1; then go to DONE.
REQ-016 Address arithmetic SHALL be modulo 2^ADDR_W (wrap-around).
REQ-017 mem_we SHALL be 0 in every cycle outside writes.
REQ-018 DONE: done=1, busy=0, test_valid=0, challenge holds; start=1 restarts per REQ-004 with done cleared the same cycle.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, all counters 0, and outputs to: challenge 0, test_data 0, test_valid 0, mem_we 0, mem_waddr 0, mem_din 0, busy 0, done 0.
REQ-020 Reset mid-run SHALL abort with no further memory writes; after release, a new start is required.

Configuration
REQ-021 With PUF_TEST_ROUNDLOG_EN defined, each SAMPLE cycle SHALL also write mem_din={zero-pad, test_result}, mem_waddr=base_addr+N_TESTS+round_index (round_index 0-based, before increment), mem_we=1; STORE is unchanged.
REQ-022 Without PUF_TEST_ROUNDLOG_EN, SAMPLE SHALL perform no memory write and no logic for it SHALL be present.

Verification (ROUND_BITS=16, N_ROUNDS=3, N_TESTS=8, base_addr=0x100)
REQ-023 mode 0, test_result=8'hA5 constant, start pulse -> SAMPLE every 17 cycles; STORE writes 3,0,3,0,0,3,0,3 at 0x100..0x107; then done=1.
REQ-024 mode 1, response alternating 1,0 -> test_data=1 on every valid; test_valid duty 50%; 32 PUF bits per round.
REQ-025 mode 2, response pattern 1,0 -> test_data all 1; switching to pattern 0,1 -> test_data all 0.
REQ-026 rst_n low during round 2 -> outputs at reset values within the same cycle; no mem_we afterwards; start after release -> a full clean run.
REQ-027 PUF_TEST_ROUNDLOG_EN defined, test_result=8'h0F -> extra writes of 0x0F at 0x108, 0x109, 0x10A, then the 8 summary words; base_addr=0x1FFC with ADDR_W=13 -> addresses wrap through 0x0000.
REQ-028 start held high throughout run -> exactly one run; a restart occurs only from DONE.

Source files
------------

// File: rtl/puf_test_ctrl.sv
// PUF test controller: feeds PUF responses (raw / XOR-pair / decimated) to an on-line
// test block, accumulates per-test pass counts per round and stores the summary words.
// Optional build macro PUF_TEST_ROUNDLOG_EN also logs each round's raw test_result.
module puf_test_ctrl #(
  parameter int N_CB       = 64,
  parameter int N_TESTS    = 8,
  parameter int ROUND_BITS = 20000,
  parameter int N_ROUNDS   = 255,
  parameter int ADDR_W     = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [N_CB-1:0]    C,
  output logic [N_CB-1:0]    challenge,
  input  logic               response,
  output logic               test_data,
  output logic               test_valid,
  input  logic [N_TESTS-1:0] test_result,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [7:0]         mem_din,
  output logic               busy,
  output logic               done
);

  localparam int BC_W  = $clog2(ROUND_BITS + 1);
  localparam int IDX_W = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SAMPLE,
    S_STORE,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    mode_q, mode_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic [BC_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]                    round_cnt_q, round_cnt_d;
  logic [IDX_W-1:0]              st_idx_q, st_idx_d;
  logic [N_TESTS-1:0][7:0]       pass_q, pass_d;
  logic                          phase_q, phase_d;
  logic                          first_q, first_d;
  logic [N_CB-1:0]               challenge_q, challenge_d;
  logic                          test_data_q, test_data_d;
  logic                          test_valid_q, test_valid_d;
  logic                          mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]             mem_waddr_q, mem_waddr_d;
  logic [7:0]                    mem_din_q, mem_din_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  // Pass counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic b);
    return (b && (v != 8'hFF)) ? (v + 8'd1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      base_q       <= '0;
      bit_cnt_q    <= '0;
      round_cnt_q  <= '0;
      st_idx_q     <= '0;
      pass_q       <= '0;
      phase_q      <= 1'b0;
      first_q      <= 1'b0;
      challenge_q  <= '0;
      test_data_q  <= 1'b0;
      test_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_din_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      bit_cnt_q    <= bit_cnt_d;
      round_cnt_q  <= round_cnt_d;
      st_idx_q     <= st_idx_d;
      pass_q       <= pass_d;
      phase_q      <= phase_d;
      first_q      <= first_d;
      challenge_q  <= challenge_d;
      test_data_q  <= test_data_d;
      test_valid_q <= test_valid_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_din_q    <= mem_din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    base_d       = base_q;
    bit_cnt_d    = bit_cnt_q;
    round_cnt_d  = round_cnt_q;
    st_idx_d     = st_idx_q;
    pass_d       = pass_q;
    phase_d      = phase_q;
    first_d      = first_q;
    challenge_d  = challenge_q;
    test_data_d  = test_data_q;
    test_valid_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_din_d    = mem_din_q;

    if (state_q == S_RUN || state_q == S_SAMPLE || state_q == S_STORE) begin
      challenge_d = C;
    end

    // Bit feed: phase alternates every RUN/SAMPLE cycle, so pairs straddle SAMPLE.
    if (state_q == S_RUN || state_q == S_SAMPLE) begin
      phase_d = ~phase_q;
      case (mode_q)
        2'd1: begin
          if (!phase_q) begin
            first_d = response;
          end else begin
            test_valid_d = 1'b1;
            test_data_d  = first_q ^ response;
          end
        end
        2'd2: begin
          if (!phase_q) begin
            test_valid_d = 1'b1;
            test_data_d  = response;
          end
        end
        default: begin
          test_valid_d = 1'b1;
          test_data_d  = response;
        end
      endcase
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          mode_d      = (mode == 2'd3) ? 2'd0 : mode;
          base_d      = base_addr;
          bit_cnt_d   = '0;
          round_cnt_d = '0;
          st_idx_d    = '0;
          pass_d      = '0;
          phase_d     = 1'b0;
          first_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (test_valid_q) begin
          if (bit_cnt_q == BC_W'(ROUND_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_SAMPLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_SAMPLE: begin
        for (int i = 0; i < N_TESTS; i++) begin
          pass_d[i] = sat_inc(pass_q[i], test_result[i]);
        end
`ifdef PUF_TEST_ROUNDLOG_EN
        mem_we_d    = 1'b1;
        mem_waddr_d = base_q + ADDR_W'(N_TESTS) + ADDR_W'(round_cnt_q);
        mem_din_d   = 8'(test_result);
`endif
        round_cnt_d = round_cnt_q + 8'd1;
        if (round_cnt_q == 8'(N_ROUNDS - 1)) begin
          state_d  = S_STORE;
          st_idx_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STORE: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = base_q + ADDR_W'(st_idx_q);
        mem_din_d   = pass_q[st_idx_q];
        if (st_idx_q == IDX_W'(N_TESTS - 1)) begin
          state_d = S_DONE;
        end else begin
          st_idx_d = st_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_SAMPLE) || (state_d == S_STORE);
    done_d = (state_d == S_DONE);
  end

  assign challenge  = challenge_q;
  assign test_data  = test_data_q;
  assign test_valid = test_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_din    = mem_din_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_puf_test_ctrl.sv
// Bench for puf_test_ctrl: table of runs checked cycle by cycle against a rule-level model.
module tb_puf_test_ctrl;
  localparam int NCB  = 64;
  localparam int NT   = 8;
  localparam int RB   = 16;
  localparam int NR   = 3;
  localparam int AW   = 13;
  localparam int MAXC = 160;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic [AW-1:0]  base_addr = '0;
  logic [NCB-1:0] C = '0;
  logic [NCB-1:0] challenge;
  logic           response = 1'b0;
  logic           test_data, test_valid;
  logic [NT-1:0]  test_result = '0;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [7:0]     mem_din;
  logic           busy, done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  puf_test_ctrl #(.N_CB(NCB), .N_TESTS(NT), .ROUND_BITS(RB), .N_ROUNDS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr), .C(C),
    .challenge(challenge), .response(response), .test_data(test_data), .test_valid(test_valid),
    .test_result(test_result), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .busy(busy), .done(done));

  // Model state per cycle: 1 RUN, 2 SAMPLE, 3 STORE, 4 DONE.
  logic           resp_a [MAXC];
  logic [NT-1:0]  tr_a   [MAXC];
  logic [NCB-1:0] c_a    [MAXC];
  int             st_a   [MAXC];
  bit             pv_a   [MAXC];
  bit             pd_a   [MAXC];
  bit             we_a   [MAXC+1];
  logic [AW-1:0]  wa_a   [MAXC+1];
  logic [7:0]     wd_a   [MAXC+1];
  int             done_k;
  logic [NCB-1:0] ch_model = '0;
  logic [7:0]     words_q [$];

  typedef struct {
    int            md;
    logic [AW-1:0] base;
    int            rk;
    bit            tr_rand;
    logic [NT-1:0] trc;
    bit            hold;
    bit            has_exp;
    logic [63:0]   words;
    int            exp_done;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle k counts from the first RUN cycle. A bit produced in cycle k is visible in k+1
  // and counts toward the round only if the controller is in RUN when it is visible.
  task automatic build_model(input int md, input logic [AW-1:0] base);
    int s, cnt, rounds, j, m;
    int pass [NT];
    bit vis;
    m = (md == 3) ? 0 : md;
    s = 1; cnt = 0; rounds = 0; j = 0; done_k = -1;
    for (int i = 0; i < NT; i++) pass[i] = 0;
    for (int k = 0; k <= MAXC; k++) begin
      we_a[k] = 1'b0; wa_a[k] = '0; wd_a[k] = '0;
    end
    for (int k = 0; k < MAXC; k++) begin
      st_a[k] = s; pv_a[k] = 1'b0; pd_a[k] = 1'b0;
      vis = (k > 0) ? pv_a[k-1] : 1'b0;
      if (s == 1 || s == 2) begin
        if (m == 0) begin
          pv_a[k] = 1'b1; pd_a[k] = resp_a[k];
        end else if (m == 1) begin
          if (k % 2 == 1) begin pv_a[k] = 1'b1; pd_a[k] = resp_a[k-1] ^ resp_a[k]; end
        end else begin
          if (k % 2 == 0) begin pv_a[k] = 1'b1; pd_a[k] = resp_a[k]; end
        end
      end
      if (s == 1) begin
        if (vis) begin
          cnt++;
          if (cnt == RB) begin cnt = 0; s = 2; end
        end
      end else if (s == 2) begin
`ifdef PUF_TEST_ROUNDLOG_EN
        we_a[k+1] = 1'b1; wa_a[k+1] = AW'(int'(base) + NT + rounds); wd_a[k+1] = 8'(tr_a[k]);
`endif
        for (int i = 0; i < NT; i++) if (tr_a[k][i] && pass[i] < 255) pass[i]++;
        rounds++;
        s = (rounds == NR) ? 3 : 1;
      end else if (s == 3) begin
        we_a[k+1] = 1'b1; wa_a[k+1] = AW'(int'(base) + j); wd_a[k+1] = 8'(pass[j]);
        j++;
        if (j == NT) s = 4;
      end else if (done_k < 0) begin
        done_k = k;
      end
    end
  endtask

  task automatic do_run(input vec_t v, input int abort_at);
    logic [NCB-1:0] ch_exp;
    for (int k = 0; k < MAXC; k++) begin
      resp_a[k] = (v.rk == 0) ? 1'($urandom) : (v.rk == 1) ? (k % 2 == 0) : (k % 2 == 1);
      tr_a[k]   = v.tr_rand ? NT'($urandom) : v.trc;
      c_a[k]    = {$urandom, $urandom};
    end
    build_model(v.md, v.base);
    words_q.delete();
    mode = 2'(v.md); base_addr = v.base; start = 1'b1;
    step();
    if (!v.hold) start = 1'b0;
    ch_exp = ch_model;
    for (int k = 0; k < MAXC; k++) begin
      if (abort_at >= 0 && k == abort_at) break;
      if (done_k >= 0 && k > done_k + 2) break;
      if (k > 0 && st_a[k-1] != 4) ch_exp = c_a[k-1];
      check("test_valid", 64'(test_valid), (k > 0) ? 64'(pv_a[k-1]) : 64'd0);
      if (k > 0 && pv_a[k-1]) check("test_data", 64'(test_data), 64'(pd_a[k-1]));
      check("busy", 64'(busy), 64'(st_a[k] < 4));
      check("done", 64'(done), 64'(st_a[k] == 4));
      check("mem_we", 64'(mem_we), 64'(we_a[k]));
      if (we_a[k]) begin
        check("mem_waddr", 64'(mem_waddr), 64'(wa_a[k]));
        check("mem_din", 64'(mem_din), 64'(wd_a[k]));
      end
      check("challenge", challenge, ch_exp);
      if (v.exp_done >= 0 && k == v.exp_done - 1) check("done_early", 64'(done), 64'd0);
      if (v.exp_done >= 0 && k == v.exp_done) check("done_at", 64'(done), 64'd1);
      if (mem_we) words_q.push_back(mem_din);
      response = resp_a[k]; test_result = tr_a[k]; C = c_a[k];
      if (v.hold && done_k >= 0 && k == done_k) start = 1'b0;
      step();
    end
    ch_model = ch_exp;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_challenge"}, challenge, 64'd0);
    check({tag, "_test_data"}, 64'(test_data), 64'd0);
    check({tag, "_test_valid"}, 64'(test_valid), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
    check({tag, "_mem_din"}, 64'(mem_din), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int sz;
    tbl[0] = '{0, 13'h100,  0, 1'b0, 8'hA5, 1'b0, 1'b1, 64'h0300030000030003, 60};
    tbl[1] = '{1, 13'h100,  1, 1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 106};
    tbl[2] = '{2, 13'h100,  1, 1'b0, 8'h0F, 1'b0, 1'b1, 64'h0000000003030303, 105};
    tbl[3] = '{2, 13'h100,  2, 1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 105};
    tbl[4] = '{3, 13'h1FFC, 0, 1'b0, 8'hFF, 1'b1, 1'b1, 64'h0303030303030303, 60};
    tbl[5] = '{1, 13'h0ABC, 0, 1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 106};
    tbl[6] = '{0, 13'h1FFE, 0, 1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 60};

    #12;
    check_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;
    step();

    // Abort in round 2, then confirm the block stays quiet until restarted.
    v = tbl[0];
    do_run(v, 25);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_rst");
    step(); step();
    rst_n = 1'b1;
    ch_model = '0;
    for (int i = 0; i < 60; i++) begin
      check("post_rst_mem_we", 64'(mem_we), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      step();
    end

    for (int r = 0; r < 7; r++) begin
      do_run(tbl[r], -1);
      if (tbl[r].has_exp) begin
        sz = words_q.size();
        check("summary_count", 64'(sz >= NT), 64'd1);
        if (sz >= NT)
          for (int i = 0; i < NT; i++)
            check("summary_word", 64'(words_q[sz-NT+i]), 64'(tbl[r].words[8*i +: 8]));
      end
    end

    for (int i = 0; i < 3; i++) begin
      check("done_hold", 64'(done), 64'd1);
      check("done_no_we", 64'(mem_we), 64'd0);
      step();
    end
    start = 1'b1; mode = 2'd0; base_addr = 13'h100;
    step();
    start = 1'b0;
    check("restart_done_cleared", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
